connect4_game_ctrl: RTL

Game-flow controller for the Connect-4 pop-out board datapath. Takes keypad move requests (drop or pop) and validates the column. Issues one command per move to the board storage over a valid/ack handshake, then reads the whole board back through a read port into a shadow copy and evaluates win/draw. Owns turn order, game-over state and per-player scores. Sits between the keypad/button front end and the board/VGA renderer.

---
 rtl/connect4_game_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/connect4_game_ctrl.sv
// rtl/connect4_game_ctrl.sv - Connect-4 pop-out game-flow controller
// Validates moves, issues one board command per move, rescans the board and scores wins.
module connect4_game_ctrl #(
    parameter int COLS    = 7,
    parameter int ROWS    = 6,
    parameter int SCORE_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_move_req,
    input  logic [3:0]         i_move_col,
    input  logic               i_move_pop,
    input  logic               i_reset_game,
    input  logic               i_reset_score,
    output logic               o_cmd_valid,
    output logic               o_cmd_pop,
    output logic [2:0]         o_cmd_col,
    output logic               o_cmd_player,
    input  logic               i_cmd_ack,
    input  logic               i_cmd_ok,
    output logic               o_board_clear,
    output logic [2:0]         o_rd_col,
    output logic [2:0]         o_rd_row,
    input  logic               i_rd_occ,
    input  logic               i_rd_color,
    output logic               o_player,
    output logic               o_busy,
    output logic               o_illegal,
    output logic               o_game_over,
    output logic [1:0]         o_winner,
    output logic [SCORE_W-1:0] o_score_red,
    output logic [SCORE_W-1:0] o_score_yel
);
    localparam int N  = COLS * ROWS;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_SCAN, S_EVAL, S_OVER} state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_req_d1, r_req_d2;
    logic                 r_cmd_valid, r_cmd_pop, r_cmd_player;
    logic [2:0]           r_cmd_col;
    logic                 r_board_clear, r_illegal, r_player;
    logic [2:0]           r_rd_col, r_rd_row, r_rd_col_d, r_rd_row_d;
    logic [CW-1:0]        r_scan_cnt;
    logic [N-1:0]         r_occ, r_red;
    logic [1:0]           r_winner;
    logic [SCORE_W-1:0]   r_score_red, r_score_yel;
    logic                 w_rise, w_start, w_bad_req, w_nack, w_ack_ok;
    logic                 w_red_win, w_yel_win, w_full;
    logic [1:0]           w_result;
    logic [IW-1:0]        w_wr_idx;

    function automatic logic f_cell(input logic [N-1:0] b, input int c, input int r);
        logic [N-1:0] t;
        if (c < 0 || c >= COLS || r < 0 || r >= ROWS) return 1'b0;
        t = b >> (c * ROWS + r);
        return t[0];
    endfunction

    // Any four in a row starting at (c,r): right, up, up-right, down-right.
    function automatic logic f_four(input logic [N-1:0] b);
        logic hit, h, v, d, a;
        hit = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                h = 1'b1; v = 1'b1; d = 1'b1; a = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    h &= f_cell(b, c + k, r);
                    v &= f_cell(b, c, r + k);
                    d &= f_cell(b, c + k, r + k);
                    a &= f_cell(b, c + k, r - k);
                end
                hit |= h | v | d | a;
            end
        end
        return hit;
    endfunction

    assign w_rise    = r_req_d1 & ~r_req_d2;
    assign w_red_win = f_four(r_occ & r_red);
    assign w_yel_win = f_four(r_occ & ~r_red);
    assign w_full    = &r_occ;
    assign w_wr_idx  = IW'(int'(r_rd_col_d) * ROWS + int'(r_rd_row_d));

    always_comb begin
        w_result = 2'b00;
        if (w_red_win && w_yel_win) w_result = r_player ? 2'b01 : 2'b10;
        else if (w_red_win)         w_result = 2'b01;
        else if (w_yel_win)         w_result = 2'b10;
        else if (w_full)            w_result = 2'b11;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_bad_req   = 1'b0;
        w_nack      = 1'b0;
        w_ack_ok    = 1'b0;
        case (r_state)
            S_IDLE: if (w_rise) begin
                if (i_move_col < 4'(COLS)) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_bad_req   = 1'b1;
                end
            end
            S_ISSUE: if (i_cmd_ack) begin
                w_ack_ok    = i_cmd_ok;
                w_nack      = ~i_cmd_ok;
                w_state_nxt = i_cmd_ok ? S_SCAN : S_IDLE;
            end
            S_SCAN:  if (r_scan_cnt == CW'(N)) w_state_nxt = S_EVAL;
            S_EVAL:  w_state_nxt = (w_result != 2'b00) ? S_OVER : S_IDLE;
            S_OVER:  w_state_nxt = S_OVER;
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_reset_game) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req_d1 <= 1'b0;  r_req_d2 <= 1'b0;
            r_cmd_valid <= 1'b0; r_cmd_pop <= 1'b0; r_cmd_col <= '0; r_cmd_player <= 1'b1;
            r_board_clear <= 1'b0; r_illegal <= 1'b0; r_player <= 1'b1;
            r_rd_col <= '0; r_rd_row <= '0; r_rd_col_d <= '0; r_rd_row_d <= '0;
            r_scan_cnt <= '0; r_occ <= '0; r_red <= '0; r_winner <= 2'b00;
            r_score_red <= '0; r_score_yel <= '0;
        end else begin
            r_req_d1      <= i_move_req;
            r_req_d2      <= r_req_d1;
            r_board_clear <= i_reset_game;
            r_rd_col_d    <= r_rd_col;
            r_rd_row_d    <= r_rd_row;

            // Score clear beats a same-cycle win increment.
            if (i_reset_score) begin
                r_score_red <= '0;
                r_score_yel <= '0;
            end else if (!i_reset_game && r_state == S_EVAL) begin
                if (w_result == 2'b01 && r_score_red != '1) r_score_red <= r_score_red + 1'b1;
                if (w_result == 2'b10 && r_score_yel != '1) r_score_yel <= r_score_yel + 1'b1;
            end

            if (i_reset_game) begin
                r_cmd_valid <= 1'b0;
                r_player    <= 1'b1;
                r_winner    <= 2'b00;
                r_illegal   <= 1'b0;
            end else begin
                r_illegal <= w_bad_req | w_nack;
                if (w_start) begin
                    r_cmd_valid  <= 1'b1;
                    r_cmd_col    <= i_move_col[2:0];
                    r_cmd_pop    <= i_move_pop;
                    r_cmd_player <= r_player;
                end else if (r_state == S_ISSUE && i_cmd_ack) begin
                    r_cmd_valid  <= 1'b0;
                end
                if (w_ack_ok) begin
                    r_rd_col   <= '0;
                    r_rd_row   <= '0;
                    r_scan_cnt <= '0;
                end
                if (r_state == S_SCAN) begin
                    r_scan_cnt <= r_scan_cnt + 1'b1;
                    // Read data lags the address by one cycle, so the first cycle captures nothing.
                    if (r_scan_cnt != '0) begin
                        r_occ[w_wr_idx] <= i_rd_occ;
                        r_red[w_wr_idx] <= i_rd_color;
                    end
                    if (r_scan_cnt < CW'(N - 1)) begin
                        if (r_rd_row == 3'(ROWS - 1)) begin
                            r_rd_row <= '0;
                            r_rd_col <= r_rd_col + 1'b1;
                        end else begin
                            r_rd_row <= r_rd_row + 1'b1;
                        end
                    end
                end
                if (r_state == S_EVAL) begin
                    if (w_result != 2'b00) r_winner <= w_result;
                    else                   r_player <= ~r_player;
                end
            end
        end
    end

    assign o_cmd_valid   = r_cmd_valid;
    assign o_cmd_pop     = r_cmd_pop;
    assign o_cmd_col     = r_cmd_col;
    assign o_cmd_player  = r_cmd_player;
    assign o_board_clear = r_board_clear;
    assign o_rd_col      = r_rd_col;
    assign o_rd_row      = r_rd_row;
    assign o_player      = r_player;
    assign o_busy        = (r_state == S_ISSUE) || (r_state == S_SCAN) || (r_state == S_EVAL);
    assign o_illegal     = r_illegal;
    assign o_game_over   = (r_state == S_OVER);
    assign o_winner      = r_winner;
    assign o_score_red   = r_score_red;
    assign o_score_yel   = r_score_yel;
endmodule
